// File: rtl/alu8_serial_ctrl.sv
// alu8_serial_ctrl: bit-serial logic/shift unit. One result bit is produced
// per clock, LSB first, into a shadow register. That register is copied to
// the result output only when the operation completes.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin an operation (only honoured in IDLE)
//   abort           cancel the running operation (only honoured in RUN)
//   op1, op2, cin   operands, captured on the accepted start
//   opsel           0 AND, 1 OR, 2 XOR, 3 NOT op1, 4 LSHIFT, 5-7 illegal
//   busy            high while bits are being computed
//   done            one-cycle completion pulse
//   result, cout    completed result and shift-out bit, held between completions
//   err             set with done for an illegal opsel, cleared on the next start
module alu8_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  input  logic [2:0]       opsel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op1, r_op2, r_shadow, r_result;
  logic             r_cin, r_busy, r_done, r_cout, r_err;
  logic [2:0]       r_opsel;

  logic             w_bit;
  logic [WIDTH-1:0] w_shadow_nxt;

  // Result bit at index r_cnt, plus the shadow with that bit merged in.
  // The final edge loads result from the merged value, so the last bit
  // does not need an extra cycle to land in the shadow first.
  always_comb begin
    w_bit = 1'b0;
    case (r_opsel)
      3'd0: w_bit = r_op1[r_cnt] & r_op2[r_cnt];
      3'd1: w_bit = r_op1[r_cnt] | r_op2[r_cnt];
      3'd2: w_bit = r_op1[r_cnt] ^ r_op2[r_cnt];
      3'd3: w_bit = ~r_op1[r_cnt];
      3'd4: w_bit = (r_cnt == '0) ? r_cin : r_op1[r_cnt - CNT_ONE];
      default: w_bit = 1'b0;
    endcase
    w_shadow_nxt        = r_shadow;
    w_shadow_nxt[r_cnt] = w_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_cin    <= 1'b0;
      r_opsel  <= 3'd0;
      r_shadow <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op1    <= op1;
            r_op2    <= op2;
            r_cin    <= cin;
            r_opsel  <= opsel;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_err    <= 1'b0;
            if (opsel <= 3'd4) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              // Illegal ops complete at once, with no RUN phase.
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_err    <= 1'b1;
              r_result <= '0;
              r_cout   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort takes priority, including on the final-bit edge.
            // Outputs keep the previous completion's values.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_shadow <= w_shadow_nxt;
            if (r_cnt == CNT_LAST) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_shadow_nxt;
              r_cout   <= (r_opsel == 3'd4) & r_op1[WIDTH-1];
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign err    = r_err;

endmodule

// File: doc/alu8_serial_ctrl.md
ALU8_SERIAL_CTRL -- requirements
Module: alu8_serial_ctrl

Interface
- REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
- REQ-002 clk  input  1  single clock; all state updates on its rising edge.
- REQ-003 rst_n  input  1  reset, asynchronous and active-low.
- REQ-004 start  input  1  request a new operation; sampled only in IDLE.
- REQ-005 abort  input  1  cancel an operation in progress; sampled only in RUN.
- REQ-006 op1  input  WIDTH  first operand; captured on the accepted start.
- REQ-007 op2  input  WIDTH  second operand; captured on the accepted start.
- REQ-008 cin  input  1  shift-in bit for LSHIFT; captured on the accepted start.
- REQ-009 opsel  input  3  operation select: 0 AND, 1 OR, 2 XOR, 3 NOT op1, 4 LSHIFT, 5-7 illegal.
- REQ-010 busy  output  1  high while in RUN.
- REQ-011 done  output  1  one-cycle completion pulse.
- REQ-012 result  output  WIDTH  completed result; held stable between completions.
- REQ-013 cout  output  1  shift-out bit (LSHIFT only; 0 for other ops).
- REQ-014 err  output  1  high with done when the operation was illegal; held until next accepted start.

Function
- REQ-015 FSM states are IDLE, RUN and DONE.
- REQ-016 In IDLE, start=1 at a rising edge SHALL capture op1, op2, cin and opsel, clear the bit counter to 0 and clear err.
- REQ-017 After that capture, a legal opsel SHALL move the FSM to RUN; an illegal opsel (5-7) SHALL move it to DONE, set err=1, and set result=0 and cout=0.
- REQ-018 In RUN, each edge SHALL compute one result bit, LSB first, at index = counter, and then increment the counter.
- REQ-019 Bit rule: AND/OR/XOR use op1[i] and op2[i]; NOT uses ~op1[i]; LSHIFT uses cin for bit 0 and op1[i-1] for i>0.
- REQ-020 Result bits SHALL accumulate in an internal shadow register; result is updated from it only on entry to DONE.
- REQ-021 The edge computing bit WIDTH-1 SHALL move the FSM to DONE; cout SHALL be op1[WIDTH-1] for LSHIFT and 0 otherwise.
- REQ-022 Latency for a legal op: start at edge E0; busy is high from E0 to E(WIDTH); done is high for the single cycle between E(WIDTH) and E(WIDTH+1).
- REQ-023 Latency for an illegal op: done is high for the single cycle between E0 and E1, and busy stays 0.
- REQ-024 DONE SHALL always return to IDLE on the next edge; done is never high for two consecutive cycles.
- REQ-025 start while in RUN or DONE SHALL be ignored and not queued; it must be reasserted in IDLE.
- REQ-026 abort=1 in RUN SHALL return the FSM to IDLE on that edge with no done pulse and with result, cout and err unchanged.
- REQ-027 If abort and the final-bit edge coincide, abort wins.
- REQ-028 Captured operands SHALL be immune to input changes during RUN.
- REQ-029 The counter SHALL be clog2(WIDTH) bits wide and SHALL never wrap within one operation.

Reset
- REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, result=0, cout=0, err=0, counter 0 and shadow register 0.
- REQ-031 Reset asserted mid-RUN SHALL discard the operation; no done pulse may follow reset release.
- REQ-032 The first start SHALL be accepted at the first edge after rst_n deasserts.

Verification
- REQ-033 Case AND: op1=0xF0, op2=0x3C, opsel=0 -> after 8 busy cycles, done pulses once with result=0x30, cout=0, err=0.
- REQ-034 Case LSHIFT: op1=0xA5, cin=1, opsel=4 -> result=0x4B, cout=1, done exactly 8 edges after start.
- REQ-035 Case NOT and XOR back-to-back: NOT with op1=0x0F gives 0xF0; start held high through DONE does not retrigger; a new start in IDLE running XOR with op1=0xFF, op2=0x0F gives 0xF0.
- REQ-036 Case illegal op: opsel=6 -> done on the cycle after start, err=1, result=0, busy never high; the next legal op clears err.
- REQ-037 Case abort: abort at the 4th RUN edge -> no done, prior result retained; abort on the final-bit edge also suppresses done.
- REQ-038 Case reset: rst_n pulled low mid-RUN between edges -> all outputs 0 immediately; no done after release.
